// File: rtl/monitor_pkg.sv
// Shared types and constants for the debug-monitor register scanner.
package monitor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HEADER   = 2'd1,
        DATA     = 2'd2,
        CHECKSUM = 2'd3
    } scan_state_t;

    localparam logic [7:0] MON_HDR = 8'hA5;

    // Bytes needed to carry one n-bit register, LS byte first.
    function automatic int unsigned bytes_per_reg(input int unsigned n);
        return (n + 7) / 8;
    endfunction

    // Index width for a counter spanning 'count' positions (never zero).
    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/reg_byte_select.sv
// Picks one zero-padded byte out of the captured register snapshot.
module reg_byte_select
    import monitor_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned NREG = 4
) (
    input  logic [NREG*N-1:0]            shadow_i,
    input  logic [idx_width(NREG)-1:0]   reg_idx_i,
    input  logic [idx_width(bytes_per_reg(N))-1:0] byte_idx_i,
    output logic [7:0]                   sel_byte_c_o
);

    localparam int unsigned BPR = bytes_per_reg(N);
    localparam int unsigned RW  = idx_width(NREG);
    localparam int unsigned BW  = idx_width(BPR);

    logic [N-1:0]       reg_val;
    logic [BPR*8-1:0]   padded;

    // Register mux, zero-extension to whole bytes, then byte mux.
    always_comb begin
        reg_val      = '0;
        padded       = '0;
        sel_byte_c_o = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (reg_idx_i == RW'(i)) begin
                reg_val = shadow_i[i*N +: N];
            end
        end
        padded[N-1:0] = reg_val;
        for (int b = 0; b < int'(BPR); b++) begin
            if (byte_idx_i == BW'(b)) begin
                sel_byte_c_o = padded[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/reg_monitor_scanner.sv
// Snapshots NREG registers on request and streams them as a framed byte
// sequence (header, data LS byte first, mod-256 checksum) over valid/ready.
module reg_monitor_scanner
    import monitor_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned NREG = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREG*N-1:0]    regs_flat,
    input  logic                 snap_req,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last
);

    localparam int unsigned BPR = bytes_per_reg(N);
    localparam int unsigned RW  = idx_width(NREG);
    localparam int unsigned BW  = idx_width(BPR);

    scan_state_t          state_q, state_d;
    logic [NREG*N-1:0]    shadow_q, shadow_d;
    logic [RW-1:0]        reg_idx_q, reg_idx_d;
    logic [BW-1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]           checksum_q, checksum_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic [7:0]           data_q, data_d;
    logic                 last_q, last_d;

    logic                 accept_c;
    logic                 last_pos_c;
    logic [RW-1:0]        sel_reg_c;
    logic [BW-1:0]        sel_byte_idx_c;
    logic [7:0]           sel_byte_c;
    logic [7:0]           sum_c;

    assign accept_c   = valid_q && out_ready;
    assign last_pos_c = (reg_idx_q == RW'(NREG - 1)) && (byte_idx_q == BW'(BPR - 1));
    assign sum_c      = checksum_q + data_q;

    // Position of the byte to present after the current accept; saturates at the end.
    always_comb begin
        sel_reg_c      = '0;
        sel_byte_idx_c = '0;
        if (state_q == DATA) begin
            if (byte_idx_q != BW'(BPR - 1)) begin
                sel_reg_c      = reg_idx_q;
                sel_byte_idx_c = BW'(byte_idx_q + 1'b1);
            end else if (reg_idx_q != RW'(NREG - 1)) begin
                sel_reg_c      = RW'(reg_idx_q + 1'b1);
                sel_byte_idx_c = '0;
            end else begin
                sel_reg_c      = reg_idx_q;
                sel_byte_idx_c = byte_idx_q;
            end
        end
    end

    reg_byte_select #(
        .N    (N),
        .NREG (NREG)
    ) u_sel (
        .shadow_i     (shadow_q),
        .reg_idx_i    (sel_reg_c),
        .byte_idx_i   (sel_byte_idx_c),
        .sel_byte_c_o (sel_byte_c)
    );

    // Frame sequencer: next state, counters, checksum and registered stream outputs.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        reg_idx_d  = reg_idx_q;
        byte_idx_d = byte_idx_q;
        checksum_d = checksum_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    state_d    = HEADER;
                    shadow_d   = regs_flat;
                    checksum_d = '0;
                    reg_idx_d  = '0;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                    valid_d    = 1'b1;
                    data_d     = MON_HDR;
                    last_d     = 1'b0;
                end
            end
            HEADER: begin
                if (accept_c) begin
                    state_d    = DATA;
                    reg_idx_d  = '0;
                    byte_idx_d = '0;
                    data_d     = sel_byte_c;
                end
            end
            DATA: begin
                if (accept_c) begin
                    checksum_d = sum_c;
                    if (last_pos_c) begin
                        state_d = CHECKSUM;
                        data_d  = sum_c;
                        last_d  = 1'b1;
                    end else begin
                        reg_idx_d  = sel_reg_c;
                        byte_idx_d = sel_byte_idx_c;
                        data_d     = sel_byte_c;
                    end
                end
            end
            CHECKSUM: begin
                if (accept_c) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            reg_idx_q  <= reg_idx_d;
            byte_idx_q <= byte_idx_d;
            checksum_q <= checksum_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_reg_monitor_scanner.sv
// Directed bench for reg_monitor_scanner across three parameter sets.
module tb_reg_monitor_scanner;

    logic        clk;
    logic        rst;
    logic        snap [3];
    logic        rdy  [3];
    logic        ov   [3];
    logic        ob   [3];
    logic        ol   [3];
    logic [7:0]  od   [3];
    logic [15:0] r0;
    logic [11:0] r1;
    logic [31:0] r2;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_monitor_scanner #(.N(8), .NREG(2)) u0 (
        .clock(clk), .reset(rst), .regs_flat(r0), .snap_req(snap[0]),
        .busy(ob[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .out_data(od[0]), .out_last(ol[0])
    );

    reg_monitor_scanner #(.N(12), .NREG(1)) u1 (
        .clock(clk), .reset(rst), .regs_flat(r1), .snap_req(snap[1]),
        .busy(ob[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .out_data(od[1]), .out_last(ol[1])
    );

    reg_monitor_scanner #(.N(8), .NREG(4)) u2 (
        .clock(clk), .reset(rst), .regs_flat(r2), .snap_req(snap[2]),
        .busy(ob[2]), .out_valid(ov[2]), .out_ready(rdy[2]),
        .out_data(od[2]), .out_last(ol[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consume a frame already presenting its header; optionally stall each byte once.
    task automatic recv(input int u, input logic [7:0] exp[$], input bit toggle, input string tag);
        for (int k = 0; k < exp.size(); k++) begin
            chk($sformatf("%s_valid%0d", tag, k), 32'(ov[u]), 32'd1);
            if (toggle) begin
                rdy[u] = 1'b0;
                @(negedge clk);
                chk($sformatf("%s_holdv%0d", tag, k), 32'(ov[u]), 32'd1);
            end
            chk($sformatf("%s_data%0d", tag, k), 32'(od[u]), 32'(exp[k]));
            chk($sformatf("%s_last%0d", tag, k), 32'(ol[u]), 32'(k == exp.size() - 1));
            chk($sformatf("%s_busy%0d", tag, k), 32'(ob[u]), 32'd1);
            rdy[u] = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("%s_endbusy", tag), 32'(ob[u]), 32'd0);
        chk($sformatf("%s_endvalid", tag), 32'(ov[u]), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        rst = 1'b0;
        for (int u = 0; u < 3; u++) begin
            snap[u] = 1'b0;
            rdy[u]  = 1'b1;
        end
        r0 = '0; r1 = '0; r2 = '0;
        repeat (2) @(negedge clk);

        // Reset state on all instances
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("rst_valid%0d", u), 32'(ov[u]), 32'd0);
            chk($sformatf("rst_busy%0d", u), 32'(ob[u]), 32'd0);
            chk($sformatf("rst_data%0d", u), 32'(od[u]), 32'd0);
            chk($sformatf("rst_last%0d", u), 32'(ol[u]), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Test 1: two 8-bit registers, ready always high
        r0 = {8'h34, 8'h12};
        snap[0] = 1'b1;
        @(negedge clk);
        snap[0] = 1'b0;
        chk("t1_latency_busy", 32'(ob[0]), 32'd1);
        q = '{8'hA5, 8'h12, 8'h34, 8'h46};
        recv(0, q, 1'b0, "t1");

        // Test 2: one 12-bit register, upper nibble zero-padded
        r1 = 12'hABC;
        snap[1] = 1'b1;
        @(negedge clk);
        snap[1] = 1'b0;
        q = '{8'hA5, 8'hBC, 8'h0A, 8'hC6};
        recv(1, q, 1'b0, "t2");

        // Test 3: stalled consumer and input change after capture
        r0 = {8'h34, 8'h12};
        snap[0] = 1'b1;
        @(negedge clk);
        snap[0] = 1'b0;
        r0 = 16'hFFFF;
        q = '{8'hA5, 8'h12, 8'h34, 8'h46};
        recv(0, q, 1'b1, "t3");

        // Test 4: snap_req held high; ignored mid-frame and at the checksum accept
        r0 = {8'h34, 8'h12};
        snap[0] = 1'b1;
        @(negedge clk);
        recv(0, q, 1'b0, "t4a");
        @(negedge clk);
        snap[0] = 1'b0;
        chk("t4_rehdr_valid", 32'(ov[0]), 32'd1);
        chk("t4_rehdr_data", 32'(od[0]), 32'hA5);
        recv(0, q, 1'b0, "t4b");

        // Test 5: reset in the middle of the data phase, then a clean frame
        rdy[0] = 1'b0;
        snap[0] = 1'b1;
        @(negedge clk);
        snap[0] = 1'b0;
        chk("t5_hdr", 32'(od[0]), 32'hA5);
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("t5_data0", 32'(od[0]), 32'h12);
        rst = 1'b0;
        rdy[0] = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 32'(ov[0]), 32'd0);
        chk("t5_rst_busy", 32'(ob[0]), 32'd0);
        chk("t5_rst_data", 32'(od[0]), 32'd0);
        chk("t5_rst_last", 32'(ol[0]), 32'd0);
        rst = 1'b1;
        rdy[0] = 1'b1;
        r0 = {8'h90, 8'h80};
        snap[0] = 1'b1;
        @(negedge clk);
        snap[0] = 1'b0;
        q = '{8'hA5, 8'h80, 8'h90, 8'h10};
        recv(0, q, 1'b0, "t5");

        // Test 6: four 0xFF registers, checksum wraps mod 256
        r2 = 32'hFFFF_FFFF;
        snap[2] = 1'b1;
        @(negedge clk);
        snap[2] = 1'b0;
        q = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        recv(2, q, 1'b0, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
